// File: rtl/sparc_exu_alu_arb.sv
// Adder arbiter and output-select sequencer for the EXU ALU: shares the adder between
// the E-stage pipeline op and an auxiliary address-generation requester.
module sparc_exu_alu_arb #(
    parameter int STARVE_MAX = 7,
    parameter int CNT_W      = 3,
    parameter int STAT_W     = 8
) (
    input  logic              rclk,
    input  logic              arst_l,
    input  logic              pipe_vld_e,
    input  logic [1:0]        pipe_op_e,
    input  logic              pipe_cin_e,
    input  logic              aux_req,
    input  logic              aux_cin,
    output logic              aux_gnt,
    output logic              pipe_stall_e,
    output logic              alu_out_sel_sum_e_l,
    output logic              alu_out_sel_rs3_e_l,
    output logic              alu_out_sel_shift_e_l,
    output logic              alu_out_sel_logic_e_l,
    output logic              alu_src_sel_aux,
    output logic              alu_cin_e,
    output logic              aux_rslt_vld,
    output logic [CNT_W-1:0]  starve_cnt,
    output logic [STAT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic             force_aux;
    logic             pipe_served;
    logic [CNT_W-1:0] starve_nxt;

    // Arbitration is gated by arst_l so the datapath sees an idle slot during reset.
    always_comb begin
        force_aux    = aux_req & (starve_cnt == STARVE_LIM);
        aux_gnt      = arst_l & aux_req & (~pipe_vld_e | force_aux);
        pipe_stall_e = arst_l & pipe_vld_e & aux_req & force_aux;
        pipe_served  = arst_l & pipe_vld_e & ~pipe_stall_e;
    end

    always_comb begin
        alu_out_sel_sum_e_l   = 1'b0;
        alu_out_sel_logic_e_l = 1'b1;
        alu_out_sel_shift_e_l = 1'b1;
        alu_out_sel_rs3_e_l   = 1'b1;
        alu_src_sel_aux       = 1'b0;
        alu_cin_e             = 1'b0;
        if (aux_gnt) begin
            alu_src_sel_aux = 1'b1;
            alu_cin_e       = aux_cin;
        end else if (pipe_served) begin
            alu_cin_e = pipe_cin_e;
            case (pipe_op_e)
                2'b00: alu_out_sel_sum_e_l = 1'b0;
                2'b01: begin
                    alu_out_sel_sum_e_l   = 1'b1;
                    alu_out_sel_logic_e_l = 1'b0;
                end
                2'b10: begin
                    alu_out_sel_sum_e_l   = 1'b1;
                    alu_out_sel_shift_e_l = 1'b0;
                end
                default: begin
                    alu_out_sel_sum_e_l = 1'b1;
                    alu_out_sel_rs3_e_l = 1'b0;
                end
            endcase
        end
    end

    // A dropped or granted request restarts the wait; otherwise count up and hold at the limit.
    always_comb begin
        starve_nxt = starve_cnt;
        if (!aux_req || aux_gnt)
            starve_nxt = '0;
        else if (starve_cnt != STARVE_LIM)
            starve_nxt = starve_cnt + CNT_W'(1);
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            starve_cnt   <= '0;
            aux_rslt_vld <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            starve_cnt   <= starve_nxt;
            aux_rslt_vld <= aux_gnt;
            if (pipe_stall_e && (stall_cnt != {STAT_W{1'b1}}))
                stall_cnt <= stall_cnt + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_sparc_exu_alu_arb.sv
// Directed bench for sparc_exu_alu_arb: reset, decode, idle-slot grant, starvation,
// stall-count saturation, request drop, mid-starvation reset and STARVE_MAX=0 priority.
module tb_sparc_exu_alu_arb;

    logic       rclk;
    logic       arst_l;
    logic       pipe_vld_e;
    logic [1:0] pipe_op_e;
    logic       pipe_cin_e;
    logic       aux_req;
    logic       aux_cin;

    logic       aux_gnt, pipe_stall_e;
    logic       sel_sum_l, sel_rs3_l, sel_shift_l, sel_logic_l;
    logic       src_aux, cin_e, rslt_vld;
    logic [2:0] starve_cnt;
    logic [7:0] stall_cnt;

    logic       aux_gnt0, pipe_stall0;
    logic       sel_sum0, sel_rs30, sel_shift0, sel_logic0;
    logic       src_aux0, cin_e0, rslt_vld0;
    logic [2:0] starve_cnt0;
    logic [7:0] stall_cnt0;

    int checks = 0;
    int errors = 0;

    logic [3:0] selBus;
    assign selBus = {sel_sum_l, sel_logic_l, sel_shift_l, sel_rs3_l};

    sparc_exu_alu_arb #(.STARVE_MAX(7), .CNT_W(3), .STAT_W(8)) dut (
        .rclk(rclk), .arst_l(arst_l), .pipe_vld_e(pipe_vld_e), .pipe_op_e(pipe_op_e),
        .pipe_cin_e(pipe_cin_e), .aux_req(aux_req), .aux_cin(aux_cin),
        .aux_gnt(aux_gnt), .pipe_stall_e(pipe_stall_e),
        .alu_out_sel_sum_e_l(sel_sum_l), .alu_out_sel_rs3_e_l(sel_rs3_l),
        .alu_out_sel_shift_e_l(sel_shift_l), .alu_out_sel_logic_e_l(sel_logic_l),
        .alu_src_sel_aux(src_aux), .alu_cin_e(cin_e), .aux_rslt_vld(rslt_vld),
        .starve_cnt(starve_cnt), .stall_cnt(stall_cnt)
    );

    sparc_exu_alu_arb #(.STARVE_MAX(0), .CNT_W(3), .STAT_W(8)) dut0 (
        .rclk(rclk), .arst_l(arst_l), .pipe_vld_e(pipe_vld_e), .pipe_op_e(pipe_op_e),
        .pipe_cin_e(pipe_cin_e), .aux_req(aux_req), .aux_cin(aux_cin),
        .aux_gnt(aux_gnt0), .pipe_stall_e(pipe_stall0),
        .alu_out_sel_sum_e_l(sel_sum0), .alu_out_sel_rs3_e_l(sel_rs30),
        .alu_out_sel_shift_e_l(sel_shift0), .alu_out_sel_logic_e_l(sel_logic0),
        .alu_src_sel_aux(src_aux0), .alu_cin_e(cin_e0), .aux_rslt_vld(rslt_vld0),
        .starve_cnt(starve_cnt0), .stall_cnt(stall_cnt0)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [1:0] op, input logic pcin,
                                 input logic req, input logic acin);
        pipe_vld_e = vld;
        pipe_op_e  = op;
        pipe_cin_e = pcin;
        aux_req    = req;
        aux_cin    = acin;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge rclk);
        #1;
    endtask

    logic [3:0] selTable [4];

    initial begin
        selTable[0] = 4'b0111;
        selTable[1] = 4'b1011;
        selTable[2] = 4'b1101;
        selTable[3] = 4'b1110;

        // Reset with both requesters active
        arst_l = 1'b0;
        applyStimulus(1'b1, 2'b01, 1'b1, 1'b1, 1'b1);
        checkOutput("rst_gnt", aux_gnt, 0);
        checkOutput("rst_stall", pipe_stall_e, 0);
        checkOutput("rst_sel", selBus, 4'b0111);
        checkOutput("rst_src", src_aux, 0);
        checkOutput("rst_cin", cin_e, 0);
        checkOutput("rst_starve", starve_cnt, 0);
        checkOutput("rst_rslt", rslt_vld, 0);
        checkOutput("rst_stallcnt", stall_cnt, 0);
        nextCycle();
        nextCycle();

        applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        arst_l = 1'b1;
        #1;
        checkOutput("rel_sel", selBus, 4'b1011);
        checkOutput("rel_cin", cin_e, 1);

        // Pipeline decode
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            applyStimulus(1'b1, 2'(i), 1'(i % 2), 1'b0, 1'b0);
            checkOutput($sformatf("dec_sel%0d", i), selBus, selTable[i]);
            checkOutput($sformatf("dec_cin%0d", i), cin_e, 32'(i % 2));
            checkOutput($sformatf("dec_gnt%0d", i), aux_gnt, 0);
        end

        // Idle slot
        nextCycle();
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b1, 1'b1);
        checkOutput("idle_gnt", aux_gnt, 1);
        checkOutput("idle_src", src_aux, 1);
        checkOutput("idle_cin", cin_e, 1);
        checkOutput("idle_stall", pipe_stall_e, 0);
        checkOutput("idle_sel", selBus, 4'b0111);
        checkOutput("idle_rslt0", rslt_vld, 0);
        nextCycle();
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_rslt1", rslt_vld, 1);
        checkOutput("idle_idle_sel", selBus, 4'b0111);
        checkOutput("idle_idle_cin", cin_e, 0);
        nextCycle();
        checkOutput("idle_rslt2", rslt_vld, 0);

        // Starvation under continuous pipeline load, followed by saturation and request drop
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b1, 1'b0);
        checkOutput("smax0_gnt", aux_gnt0, 1);
        checkOutput("smax0_stall", pipe_stall0, 1);
        for (int c = 0; c <= 2405; c++) begin
            if (c == 2404) applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
            if (c <= 6) begin
                checkOutput($sformatf("starve_cnt_c%0d", c), starve_cnt, 32'(c));
                checkOutput($sformatf("starve_gnt_c%0d", c), aux_gnt, 0);
                checkOutput($sformatf("starve_sel_c%0d", c), selBus, 4'b1101);
            end else if (c == 7) begin
                checkOutput("force_cnt", starve_cnt, 7);
                checkOutput("force_gnt", aux_gnt, 1);
                checkOutput("force_stall", pipe_stall_e, 1);
                checkOutput("force_sel", selBus, 4'b0111);
                checkOutput("force_src", src_aux, 1);
                checkOutput("force_stallcnt", stall_cnt, 0);
            end else if (c == 8) begin
                checkOutput("after_cnt", starve_cnt, 0);
                checkOutput("after_stallcnt", stall_cnt, 1);
                checkOutput("after_rslt", rslt_vld, 1);
                checkOutput("after_gnt", aux_gnt, 0);
                checkOutput("after_sel", selBus, 4'b1101);
            end else if (c == 8 * 254) begin
                checkOutput("stallcnt_254", stall_cnt, 254);
            end else if (c == 8 * 256) begin
                checkOutput("stallcnt_sat", stall_cnt, 255);
            end else if (c == 2400) begin
                checkOutput("stallcnt_300", stall_cnt, 255);
                checkOutput("cnt_2400", starve_cnt, 0);
            end else if (c == 2403) begin
                checkOutput("drop_cnt3", starve_cnt, 3);
            end else if (c == 2404) begin
                checkOutput("drop_gnt", aux_gnt, 0);
                checkOutput("drop_cnt4", starve_cnt, 4);
            end else if (c == 2405) begin
                checkOutput("drop_clear", starve_cnt, 0);
                checkOutput("drop_rslt", rslt_vld, 0);
            end
            nextCycle();
        end

        // Reset asserted mid-starvation
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("mid_cnt3", starve_cnt, 3);
        arst_l = 1'b0;
        #1;
        checkOutput("mid_rst_cnt", starve_cnt, 0);
        checkOutput("mid_rst_stallcnt", stall_cnt, 0);
        checkOutput("mid_rst_gnt", aux_gnt, 0);
        #1;
        arst_l = 1'b1;
        nextCycle();
        checkOutput("mid_restart", starve_cnt, 1);
        checkOutput("mid_sel", selBus, 4'b0111);
        checkOutput("mid_gnt", aux_gnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
